// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and prescaler sizing helpers for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } ledMode_t;

  function automatic int prescDiv(input int clkFreq, input int tickHz);
    return clkFreq / tickHz;
  endfunction

  function automatic int prescWidth(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/half-period registers, tick counter, blink phase and
// triangle-ramped duty; produces the unregistered lit level.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int DIV_W        = 10,
  parameter int PWM_W        = 8,
  parameter int DEFAULT_HALF = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwmCnt,
  input  logic             wrEn,
  input  logic [1:0]       wrMode,
  input  logic [DIV_W-1:0] wrHalf,
  output logic             lit
);

  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

  ledMode_t         modeR;
  logic [DIV_W-1:0] halfR;
  logic [DIV_W-1:0] cntR;
  logic             phaseR;
  logic [PWM_W-1:0] dutyR;
  logic             dirDownR;

  logic [DIV_W-1:0] effHalf;
  logic             timed;
  logic             stepS;
  logic [PWM_W-1:0] dutyNext;
  logic             dirDownNext;

  // Step detection; a stored half of 0 behaves as 1
  always_comb begin
    effHalf = halfR;
    if (halfR == {DIV_W{1'b0}}) begin
      effHalf = DIV_W'(1);
    end else begin
      effHalf = halfR;
    end
    timed = (modeR == MODE_BLINK) || (modeR == MODE_BREATHE);
    stepS = tick && timed && (cntR == (effHalf - DIV_W'(1)));
  end

  // Duty reflects at both extremes so each extreme lasts exactly one step
  always_comb begin
    dutyNext    = dutyR;
    dirDownNext = dirDownR;
    if (!dirDownR) begin
      if (dutyR == DUTY_MAX) begin
        dutyNext    = dutyR - PWM_W'(1);
        dirDownNext = 1'b1;
      end else begin
        dutyNext = dutyR + PWM_W'(1);
      end
    end else begin
      if (dutyR == {PWM_W{1'b0}}) begin
        dutyNext    = dutyR + PWM_W'(1);
        dirDownNext = 1'b0;
      end else begin
        dutyNext = dutyR - PWM_W'(1);
      end
    end
  end

  // Lit level from the current mode
  always_comb begin
    lit = 1'b0;
    case (modeR)
      MODE_OFF:     lit = 1'b0;
      MODE_ON:      lit = 1'b1;
      MODE_BLINK:   lit = phaseR;
      MODE_BREATHE: lit = (pwmCnt < dutyR);
      default:      lit = 1'b0;
    endcase
  end

  // Channel state; a write overrides any step landing in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      modeR    <= MODE_OFF;
      halfR    <= DIV_W'(DEFAULT_HALF);
      cntR     <= {DIV_W{1'b0}};
      phaseR   <= 1'b0;
      dutyR    <= {PWM_W{1'b0}};
      dirDownR <= 1'b0;
    end else if (wrEn) begin
      modeR    <= ledMode_t'(wrMode);
      halfR    <= wrHalf;
      cntR     <= {DIV_W{1'b0}};
      phaseR   <= 1'b0;
      dutyR    <= {PWM_W{1'b0}};
      dirDownR <= 1'b0;
    end else if (tick && timed) begin
      if (stepS) begin
        cntR <= {DIV_W{1'b0}};
        if (modeR == MODE_BLINK) begin
          phaseR <= ~phaseR;
        end else begin
          dutyR    <= dutyNext;
          dirDownR <= dirDownNext;
        end
      end else begin
        cntR <= cntR + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter,
// runtime-configurable per-channel modes, registered LED drive.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_FREQ     = 12000000,
  parameter int TICK_HZ      = 1000,
  parameter int NUM_CH       = 3,
  parameter int DIV_W        = 10,
  parameter int PWM_W        = 8,
  parameter int DEFAULT_HALF = 500,
  parameter int ACTIVE_LOW   = 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_half,
  output logic              tick_o,
  output logic [NUM_CH-1:0] led_o
);

  localparam int               DIV      = prescDiv(CLK_FREQ, TICK_HZ);
  localparam int               PRE_W    = prescWidth(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic             ACT_LVL  = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]  prescCnt;
  logic [PWM_W-1:0]  pwmCnt;
  logic [NUM_CH-1:0] wrEn;
  logic [NUM_CH-1:0] litS;

  assign tick_o = enable && (prescCnt == PRE_LAST);

  // Prescaler holds its count while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescCnt <= {PRE_W{1'b0}};
    end else if (enable) begin
      if (prescCnt == PRE_LAST) begin
        prescCnt <= {PRE_W{1'b0}};
      end else begin
        prescCnt <= prescCnt + PRE_W'(1);
      end
    end
  end

  // Free-running PWM counter, ready flag and registered LED drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwmCnt    <= {PWM_W{1'b0}};
      cfg_ready <= 1'b0;
      led_o     <= {NUM_CH{ACT_LVL}};
    end else begin
      pwmCnt    <= pwmCnt + PWM_W'(1);
      cfg_ready <= 1'b1;
      led_o     <= litS ^ {NUM_CH{ACT_LVL}};
    end
  end

  // Out-of-range channel numbers decode to no write strobe
  always_comb begin
    wrEn = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      wrEn[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gChan
    led_channel #(
      .DIV_W       (DIV_W),
      .PWM_W       (PWM_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) uChan (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_o),
      .pwmCnt(pwmCnt),
      .wrEn  (wrEn[g]),
      .wrMode(cfg_mode),
      .wrHalf(cfg_half),
      .lit   (litS[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen against a tick-counting reference model.
module tb_led_pattern_gen;

  localparam int CLK_FREQ     = 100;
  localparam int TICK_HZ      = 10;
  localparam int NUM_CH       = 3;
  localparam int DIV_W        = 10;
  localparam int PWM_W        = 3;
  localparam int DEFAULT_HALF = 500;
  localparam int ACTIVE_LOW   = 1;
  localparam int DIV          = CLK_FREQ / TICK_HZ;
  localparam int DMAX         = (1 << PWM_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DIV_W-1:0]  cfg_half;
  logic              tick_o;
  logic [NUM_CH-1:0] led_o;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .TICK_HZ     (TICK_HZ),
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .PWM_W       (PWM_W),
    .DEFAULT_HALF(DEFAULT_HALF),
    .ACTIVE_LOW  (ACTIVE_LOW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_half (cfg_half),
    .tick_o   (tick_o),
    .led_o    (led_o)
  );

  int nCompared = 0;
  int nMismatch = 0;
  bit checkOn   = 1'b0;

  // Model: enabled-cycle count, cycle count, and ticks seen since each write
  int                mPresc;
  int                mPwm;
  bit                mReady;
  int                mMode  [NUM_CH];
  int                mHalf  [NUM_CH];
  int                mTicks [NUM_CH];
  logic [NUM_CH-1:0] mLed;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit modelTick();
    return enable && (mPresc == DIV - 1);
  endfunction

  function automatic bit modelLit(input int ch);
    int h;
    int steps;
    int t;
    int duty;
    h     = (mHalf[ch] == 0) ? 1 : mHalf[ch];
    steps = mTicks[ch] / h;
    case (mMode[ch])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (steps % 2) == 1;
      default: begin
        t    = steps % (2 * DMAX);
        duty = (t <= DMAX) ? t : (2 * DMAX - t);
        return mPwm < duty;
      end
    endcase
  endfunction

  task automatic modelEdge();
    bit tk;
    if (!rst_n) begin
      mPresc = 0;
      mPwm   = 0;
      mReady = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        mMode[i]  = 0;
        mHalf[i]  = DEFAULT_HALF;
        mTicks[i] = 0;
      end
      mLed = '1;
    end else begin
      tk = modelTick();
      for (int i = 0; i < NUM_CH; i++) begin
        mLed[i] = modelLit(i) ^ (ACTIVE_LOW != 0);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_valid && mReady && (int'(cfg_ch) == i)) begin
          mMode[i]  = int'(cfg_mode);
          mHalf[i]  = int'(cfg_half);
          mTicks[i] = 0;
        end else if (tk && (mMode[i] >= 2)) begin
          mTicks[i]++;
        end
      end
      if (enable) mPresc = (mPresc + 1) % DIV;
      mPwm   = (mPwm + 1) % (DMAX + 1);
      mReady = 1'b1;
    end
  endtask

  // Called at a falling edge with inputs set: check, advance model, wait a cycle
  task automatic cycle();
    #1;
    if (checkOn) begin
      checkEq("tick_o", 32'(tick_o), 32'(modelTick()));
      checkEq("led_o", 32'(led_o), 32'(mLed));
      checkEq("cfg_ready", 32'(cfg_ready), 32'(mReady));
    end
    modelEdge();
    @(negedge clk);
  endtask

  task automatic writeCfg(input int ch, input int mode, input int half);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_half  = DIV_W'(half);
    cycle();
    cfg_valid = 1'b0;
    cfg_ch    = 2'($urandom_range(0, 3));
    cfg_mode  = 2'($urandom_range(0, 3));
    cfg_half  = DIV_W'($urandom_range(0, 7));
  endtask

  initial begin
    bit found;
    int h;
    rst_n     = 1'b0;
    enable    = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_mode  = 2'd0;
    cfg_half  = '0;
    @(negedge clk);
    cycle();
    checkOn = 1'b1;
    repeat (4) cycle();
    rst_n = 1'b1;
    repeat (25) cycle();

    writeCfg(1, 2, 3);
    repeat (100) cycle();
    enable = 1'b0;
    repeat (50) cycle();
    enable = 1'b1;
    repeat (80) cycle();

    writeCfg(0, 3, 1);
    repeat (300) cycle();

    writeCfg(3, 1, 5);
    repeat (20) cycle();
    writeCfg(2, 2, 0);
    repeat (60) cycle();

    // Land a rewrite of ch1 on a cycle where its step would fire
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      h = (mHalf[1] == 0) ? 1 : mHalf[1];
      if (modelTick() && (mMode[1] == 2) && (((mTicks[1] + 1) % h) == 0)) begin
        found = 1'b1;
      end else begin
        cycle();
      end
    end
    checkEq("step_wait", 32'(found), 32'd1);
    writeCfg(1, 2, 2);
    repeat (80) cycle();

    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom_range(0, 99) >= 5);
      cfg_valid = ($urandom_range(0, 39) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_half  = DIV_W'($urandom_range(0, 4));
      cycle();
    end
    cfg_valid = 1'b0;
    enable    = 1'b1;

    writeCfg(0, 3, 2);
    repeat (100) cycle();
    rst_n     = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_mode  = 2'd1;
    cfg_half  = DIV_W'(3);
    cycle();
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    repeat (30) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
